// File: rtl/mem_dualport_clr_if.sv
// Bus bundle for mem_dualport_clr: write port, read port, clear request
// and the read/clear status returned by the memory.
interface mem_dualport_clr_if #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 512
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             clr;
    logic             we;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] d;
    logic             re;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             busy;

    modport master (
        output clr, we, wa, d, re, ra,
        input  q, q_valid, busy
    );

    modport slave (
        input  clr, we, wa, d, re, ra,
        output q, q_valid, busy
    );
endinterface

// File: rtl/mem_dualport_clr.sv
// Dual-port RAM with a one-word-per-cycle clear sweep and 1/2-cycle reads.
// Define MEM_DUALPORT_WR_BYPASS_EN to forward same-address write data to reads.
module mem_dualport_clr #(
    parameter int WIDTH  = 20,
    parameter int DEPTH  = 512,
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    mem_dualport_clr_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state;
    logic             busy_r;
    logic [AW-1:0]    sweep;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             wa_ok;
    logic             ra_ok;
    logic             wr_user;
    logic             rd_issue;
    logic             mem_we;
    logic [AW-1:0]    mem_wa;
    logic [WIDTH-1:0] mem_wd;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] q_r;
    logic             qv_r;

    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
        $error("mem_dualport_clr: RD_LAT must be 1 or 2");
    end

    // Only a non-power-of-two depth has unmapped addresses
    if (DEPTH == (1 << AW)) begin : g_pow2
        assign wa_ok = 1'b1;
        assign ra_ok = 1'b1;
    end else begin : g_npow2
        assign wa_ok = (bus.wa <= LAST);
        assign ra_ok = (bus.ra <= LAST);
    end

    assign wr_user  = bus.we && wa_ok && !busy_r && !rst;
    assign rd_issue = bus.re && !busy_r && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLEAR;
            busy_r <= 1'b1;
            sweep  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.clr) begin
                        state  <= CLEAR;
                        busy_r <= 1'b1;
                        sweep  <= '0;
                    end
                end
                CLEAR: begin
                    if (sweep == LAST) begin
                        state  <= IDLE;
                        busy_r <= 1'b0;
                    end else begin
                        sweep <= sweep + 1'b1;
                    end
                end
            endcase
        end
    end

    // The sweep and user writes share one physical write port
    always_comb begin
        mem_we = busy_r || wr_user;
        mem_wa = busy_r ? sweep : bus.wa;
        mem_wd = busy_r ? '0 : bus.d;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_comb begin
        rd_word = '0;
        if (ra_ok) begin
            rd_word = mem[bus.ra];
        end
`ifdef MEM_DUALPORT_WR_BYPASS_EN
        if (wr_user && (bus.wa == bus.ra)) begin
            rd_word = bus.d;
        end
`endif
    end

    if (RD_LAT == 2) begin : g_lat2
        logic             s1_v;
        logic [WIDTH-1:0] s1_d;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_v <= 1'b0;
                s1_d <= '0;
                qv_r <= 1'b0;
                q_r  <= '0;
            end else begin
                s1_v <= rd_issue;
                if (rd_issue) begin
                    s1_d <= rd_word;
                end
                qv_r <= s1_v;
                if (s1_v) begin
                    q_r <= s1_d;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clk) begin
            if (rst) begin
                qv_r <= 1'b0;
                q_r  <= '0;
            end else begin
                qv_r <= rd_issue;
                if (rd_issue) begin
                    q_r <= rd_word;
                end
            end
        end
    end

    assign bus.q       = q_r;
    assign bus.q_valid = qv_r;
    assign bus.busy    = busy_r;
endmodule
